gb_host_master: RTL and testbench

- Upstream driver for the ghostbus slave port of `top`. It produces `gb_addr`, `gb_wdata`, `gb_wen` and `gb_rstb`, and it consumes `gb_rdata`.
- Host-side reads and writes arrive on a valid/ready command channel and are buffered in a small command FIFO.
- Each command becomes a single-cycle ghostbus strobe.
- For reads, the block waits the fixed read latency, captures `gb_rdata` and returns it on a valid/ready response channel, in command order.

---
 rtl/gb_host_master.sv | 148 ++++++++++++++
 tb/tb_gb_host_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_host_master.sv
// rtl/gb_host_master.sv - ghostbus host master: command FIFO, strobe FSM, read response path; optional GB_HOST_XACT_CNT_EN strobe counters
module gb_host_master #(
    parameter int AW         = 24,
    parameter int DW         = 32,
    parameter int READ_DELAY = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          gb_clk,
    input  logic          gb_rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [AW-1:0] rsp_addr,
    output logic [DW-1:0] rsp_rdata,
    output logic          busy,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_wen,
    output logic          gb_rstb,
`ifdef GB_HOST_XACT_CNT_EN
    output logic [15:0]   wr_count,
    output logic [15:0]   rd_count,
`endif
    input  logic [DW-1:0] gb_rdata
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(READ_DELAY) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic          fifo_write [FIFO_DEPTH];
    logic [AW-1:0] fifo_addr  [FIFO_DEPTH];
    logic [DW-1:0] fifo_wdata [FIFO_DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [PW:0]   wr_ptr_nxt;
    logic [PW:0]   rd_ptr_nxt;
    logic          push;
    logic          pop;
    logic          empty;
    logic          cur_write;
    logic [CW-1:0] delay_cnt;

    assign empty      = (wr_ptr == rd_ptr);
    assign push       = cmd_valid & cmd_ready;
    assign pop        = (state == IDLE) & ~empty;
    assign wr_ptr_nxt = wr_ptr + {{PW{1'b0}}, push};
    assign rd_ptr_nxt = rd_ptr + {{PW{1'b0}}, pop};
    assign busy       = ~empty | (state != IDLE);

    // Command storage; contents need no reset since the pointers gate every read
    always_ff @(posedge gb_clk) begin
        if (push) begin
            fifo_write[wr_ptr[PW-1:0]] <= cmd_write;
            fifo_addr[wr_ptr[PW-1:0]]  <= cmd_addr;
            fifo_wdata[wr_ptr[PW-1:0]] <= cmd_wdata;
        end
    end

    // Pointers, and cmd_ready registered as "not full" of the post-edge occupancy
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_ready <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            cmd_ready <= ((wr_ptr_nxt - rd_ptr_nxt) != (PW+1)'(FIFO_DEPTH));
        end
    end

    // Issue FSM: pop, strobe for one cycle, then wait out the read latency and hold the response
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            state     <= IDLE;
            gb_addr   <= '0;
            gb_wdata  <= '0;
            gb_wen    <= 1'b0;
            gb_rstb   <= 1'b0;
            cur_write <= 1'b0;
            delay_cnt <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        gb_addr   <= fifo_addr[rd_ptr[PW-1:0]];
                        gb_wdata  <= fifo_wdata[rd_ptr[PW-1:0]];
                        cur_write <= fifo_write[rd_ptr[PW-1:0]];
                        gb_wen    <= fifo_write[rd_ptr[PW-1:0]];
                        gb_rstb   <= ~fifo_write[rd_ptr[PW-1:0]];
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    gb_wen  <= 1'b0;
                    gb_rstb <= 1'b0;
                    if (cur_write) begin
                        state <= IDLE;
                    end else begin
                        delay_cnt <= CW'(READ_DELAY - 1);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // gb_addr still holds the strobed address here
                    if (delay_cnt == '0) begin
                        rsp_rdata <= gb_rdata;
                        rsp_addr  <= gb_addr;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        delay_cnt <= delay_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GB_HOST_XACT_CNT_EN
    // Strobe counters, bumped the cycle after each strobe and wrapping freely
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (gb_wen)  wr_count <= wr_count + 16'd1;
            if (gb_rstb) rd_count <= rd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gb_host_master.sv
// tb/tb_gb_host_master.sv - directed self-checking bench for gb_host_master
module tb_gb_host_master;
    localparam int AW = 24;
    localparam int DW = 32;

    logic          gb_clk = 1'b0;
    logic          gb_rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_wdata;
    logic          gb_wen;
    logic          gb_rstb;
    logic [DW-1:0] gb_rdata;

    logic          c1_valid = 1'b0;
    logic          c1_ready;
    logic [AW-1:0] c1_addr = '0;
    logic          r1_valid;
    logic          r1_ready = 1'b1;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_rdata;
    logic          busy1;
    logic [AW-1:0] gb_addr1;
    logic [DW-1:0] gb_wdata1;
    logic          gb_wen1;
    logic          gb_rstb1;
    logic [DW-1:0] gb_rdata1;
`ifdef GB_HOST_XACT_CNT_EN
    logic [15:0]   wr_count;
    logic [15:0]   rd_count;
    logic [15:0]   wr_count1;
    logic [15:0]   rd_count1;
`endif

    always #5 gb_clk = ~gb_clk;

    gb_host_master #(.AW(AW), .DW(DW), .READ_DELAY(3), .FIFO_DEPTH(4)) dut (
        .gb_clk(gb_clk), .gb_rst(gb_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
        .busy(busy), .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_wen(gb_wen), .gb_rstb(gb_rstb),
`ifdef GB_HOST_XACT_CNT_EN
        .wr_count(wr_count), .rd_count(rd_count),
`endif
        .gb_rdata(gb_rdata)
    );

    gb_host_master #(.AW(AW), .DW(DW), .READ_DELAY(1), .FIFO_DEPTH(4)) dut1 (
        .gb_clk(gb_clk), .gb_rst(gb_rst),
        .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_write(1'b0),
        .cmd_addr(c1_addr), .cmd_wdata(32'h0),
        .rsp_valid(r1_valid), .rsp_ready(r1_ready), .rsp_addr(r1_addr), .rsp_rdata(r1_rdata),
        .busy(busy1), .gb_addr(gb_addr1), .gb_wdata(gb_wdata1), .gb_wen(gb_wen1), .gb_rstb(gb_rstb1),
`ifdef GB_HOST_XACT_CNT_EN
        .wr_count(wr_count1), .rd_count(rd_count1),
`endif
        .gb_rdata(gb_rdata1)
    );

    // ghostbus slave model, latency 3: memory preset to 0x1000+addr, poison outside the valid cycle
    logic [DW-1:0] mem [256];
    logic [2:0]    rs_v;
    logic [AW-1:0] rs_a [3];
    always @(posedge gb_clk) begin
        if (gb_rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000 + i;
            rs_v <= '0;
        end else begin
            if (gb_wen) mem[gb_addr[7:0]] <= gb_wdata;
            rs_v <= {rs_v[1:0], gb_rstb};
        end
        rs_a[0] <= gb_addr;
        rs_a[1] <= rs_a[0];
        rs_a[2] <= rs_a[1];
    end
    assign gb_rdata = rs_v[2] ? mem[rs_a[2][7:0]] : 32'hdeadbeef;

    // latency-1 slave for dut1
    logic          s1_v;
    logic [AW-1:0] s1_a;
    always @(posedge gb_clk) begin
        s1_v <= gb_rstb1;
        s1_a <= gb_addr1;
    end
    assign gb_rdata1 = s1_v ? (32'h5500_0000 | {8'h00, s1_a}) : 32'hdeadbeef;

    int cyc = 0;
    always @(posedge gb_clk) cyc <= cyc + 1;

    int            wcyc  [$];
    logic [AW-1:0] waddr [$];
    logic [DW-1:0] wdat  [$];
    int            rcyc  [$];
    logic [AW-1:0] raddr [$];
    bit            both_hi = 1'b0;
    always @(negedge gb_clk) begin
        if (gb_wen) begin
            wcyc.push_back(cyc);
            waddr.push_back(gb_addr);
            wdat.push_back(gb_wdata);
        end
        if (gb_rstb) begin
            rcyc.push_back(cyc);
            raddr.push_back(gb_addr);
        end
        if (gb_wen && gb_rstb) both_hi = 1'b1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // present a command from a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, output int pcyc);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && n < 200) begin
            @(negedge gb_clk);
            n++;
        end
        if (n >= 200) check_eq("push_timeout", 0, 1);
        @(negedge gb_clk);
        pcyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input logic [AW-1:0] a, input logic [DW-1:0] d, output int vcyc);
        int n = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 200) begin
            @(negedge gb_clk);
            n++;
        end
        if (n >= 200) check_eq("rsp_timeout", 0, 1);
        vcyc = cyc;
        check_eq("rsp_addr", rsp_addr, a);
        check_eq("rsp_rdata", rsp_rdata, d);
        @(negedge gb_clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int p1, p2, v, t, n, wb, rb, rs1, v1;
        repeat (3) @(negedge gb_clk);
        check_eq("rst_cmd_ready", cmd_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_strobes", {gb_wen, gb_rstb}, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_gb_addr", gb_addr, 0);
        check_eq("rst_gb_wdata", gb_wdata, 0);
        gb_rst = 1'b0;
        @(negedge gb_clk);
        check_eq("cmd_ready_after_rst", cmd_ready, 1);

        // READ_DELAY=1 instance: response two cycles after the read strobe
        check_eq("d1_ready", c1_ready, 1);
        c1_valid = 1'b1; c1_addr = 24'h000004;
        @(negedge gb_clk);
        c1_valid = 1'b0;
        n = 0;
        while (!gb_rstb1 && n < 20) begin @(negedge gb_clk); n++; end
        rs1 = cyc;
        while (!r1_valid && n < 40) begin @(negedge gb_clk); n++; end
        v1 = cyc;
        check_eq("d1_rsp_latency", v1 - rs1, 2);
        check_eq("d1_rdata", r1_rdata, 32'h5500_0004);
        check_eq("d1_addr", r1_addr, 24'h000004);

        // write 0 <- 0xcc then read it back
        wb = wcyc.size(); rb = rcyc.size();
        push(1'b1, 24'h000000, 32'h000000cc, p1);
        push(1'b0, 24'h000000, 32'h0, p2);
        wait_rsp(24'h000000, 32'h000000cc, v);
        check_eq("t1_wen_latency", wcyc[wb] - p1, 1);
        check_eq("t1_wen_addr", waddr[wb], 0);
        check_eq("t1_wen_data", wdat[wb], 32'hcc);
        check_eq("t1_rstb_after_wen", rcyc[rb] - wcyc[wb], 2);
        check_eq("t1_rstb_addr", raddr[rb], 0);
        check_eq("t1_rsp_latency", v - rcyc[rb], 4);

        // three reads with the response stalled, then writes fill the FIFO behind them
        wb = wcyc.size(); rb = rcyc.size();
        push(1'b0, 24'h000020, 32'h0, p1);
        push(1'b0, 24'h000021, 32'h0, p1);
        push(1'b0, 24'h000022, 32'h0, p1);
        repeat (20) @(negedge gb_clk);
        check_eq("t3_one_rstb", rcyc.size() - rb, 1);
        check_eq("t3_rsp_held", rsp_valid, 1);
        check_eq("t3_rsp_data_held", rsp_rdata, 32'h1020);
        check_eq("t3_rsp_addr_held", rsp_addr, 24'h20);
        push(1'b1, 24'h000040, 32'h000000a0, p1);
        push(1'b1, 24'h000041, 32'h000000a1, p1);
        check_eq("t2_full_ready_low", cmd_ready, 0);
        check_eq("t2_busy", busy, 1);
        fork
            begin
                push(1'b1, 24'h000042, 32'h000000a2, p2);
                push(1'b1, 24'h000043, 32'h000000a3, p2);
                push(1'b1, 24'h000044, 32'h000000a4, p2);
            end
            begin
                wait_rsp(24'h000020, 32'h1020, t);
                wait_rsp(24'h000021, 32'h1021, t);
                wait_rsp(24'h000022, 32'h1022, v);
            end
        join
        repeat (30) @(negedge gb_clk);
        check_eq("t3_rstb_count", rcyc.size() - rb, 3);
        check_eq("t2_wen_count", wcyc.size() - wb, 5);
        check_eq("t2_write_after_read", wcyc[wb] > v, 1);
        for (int i = 0; i < 5; i++) begin
            check_eq("t2_wen_addr", waddr[wb+i], 24'h40 + i);
            check_eq("t2_wen_data", wdat[wb+i], 32'ha0 + i);
            if (i > 0) check_eq("t2_wen_spacing", wcyc[wb+i] - wcyc[wb+i-1], 2);
        end
        check_eq("idle_busy", busy, 0);
`ifdef GB_HOST_XACT_CNT_EN
        check_eq("wr_count", wr_count, 6);
        check_eq("rd_count", rd_count, 4);
`endif

        // reset during WAIT aborts the read
        push(1'b0, 24'h000005, 32'h0, p1);
        n = 0;
        while (!gb_rstb && n < 20) begin @(negedge gb_clk); n++; end
        @(negedge gb_clk);
        gb_rst = 1'b1;
        #1;
        check_eq("t4_rsp_valid_in_rst", rsp_valid, 0);
        check_eq("t4_busy_in_rst", busy, 0);
        check_eq("t4_ready_in_rst", cmd_ready, 0);
        @(negedge gb_clk);
        @(negedge gb_clk);
        gb_rst = 1'b0;
        @(negedge gb_clk);
        check_eq("t4_ready_after", cmd_ready, 1);
        repeat (8) @(negedge gb_clk);
        check_eq("t4_no_rsp", rsp_valid, 0);
        check_eq("t4_busy_after", busy, 0);

        // reset during a strobe drops it without waiting for a clock
        push(1'b1, 24'h000007, 32'h00000077, p1);
        n = 0;
        while (!gb_wen && n < 20) begin @(negedge gb_clk); n++; end
        gb_rst = 1'b1;
        #1;
        check_eq("t4_wen_async_drop", gb_wen, 0);
        @(negedge gb_clk);
        gb_rst = 1'b0;
        @(negedge gb_clk);
        push(1'b0, 24'h000006, 32'h0, p1);
        wait_rsp(24'h000006, 32'h1006, v);

`ifdef GB_HOST_XACT_CNT_EN
        check_eq("rd_count_after_rst", rd_count, 1);
        force dut.wr_count = 16'hffff;
        @(negedge gb_clk);
        release dut.wr_count;
        push(1'b1, 24'h000008, 32'h88, p1);
        repeat (4) @(negedge gb_clk);
        check_eq("wr_count_wrap", wr_count, 0);
`endif

        check_eq("never_both_strobes", both_hi, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
